// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int calc_iter(input int w, input int bpc);
        return w / bpc;
    endfunction

    // Count must reach ITER itself: that value marks the sign-correction cycle.
    function automatic int calc_cnt_w(input int w, input int bpc);
        return clog2(w / bpc + 1);
    endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Partial product of the multiplicand magnitude and one multiplier digit.
module mult_pp_gen #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]                mag_a,
    input  logic [BITS_PER_CYCLE-1:0]       digit,
    output logic [WIDTH+BITS_PER_CYCLE-1:0] pp
);

    localparam int PW = WIDTH + BITS_PER_CYCLE;

    assign pp = PW'(mag_a) * PW'(digit);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits per RUN cycle.
// Optional MULT_EARLY_TERM_EN: leave RUN once the remaining multiplier is zero.
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | one digit per cycle; extra final cycle sign-corrects into result
// DONE  | result presented, held until out_ready
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int ITER = calc_iter(WIDTH, BITS_PER_CYCLE);
    localparam int CW   = calc_cnt_w(WIDTH, BITS_PER_CYCLE);
    localparam int PW   = WIDTH + BITS_PER_CYCLE;
    localparam int RW   = 2 * WIDTH;
    localparam int SW   = clog2(RW);

    if (WIDTH < 2) begin : g_bad_width
        $error("seq_multiplier: WIDTH must be at least 2");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("seq_multiplier: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    state_t           state, state_nxt;
    logic [RW-1:0]    acc, result_q, pp_shifted;
    logic [WIDTH-1:0] mag_a, mag_b, abs_a, abs_b;
    logic             neg, a_neg, b_neg, last;
    logic [CW-1:0]    count;
    logic [PW-1:0]    pp;
    logic [SW-1:0]    shamt;

    mult_pp_gen #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp_gen (
        .mag_a (mag_a),
        .digit (mag_b[BITS_PER_CYCLE-1:0]),
        .pp    (pp)
    );

    assign a_neg      = signed_mode & a[WIDTH-1];
    assign b_neg      = signed_mode & b[WIDTH-1];
    assign abs_a      = a_neg ? -a : a;
    assign abs_b      = b_neg ? -b : b;
    assign shamt      = SW'(count) * SW'(BITS_PER_CYCLE);
    assign pp_shifted = RW'(pp) << shamt;
    assign result     = result_q;

    always_comb begin
        last = (count == CW'(ITER));
`ifdef MULT_EARLY_TERM_EN
        // At least one digit is always consumed, so b=0 still spends one RUN cycle.
        if ((mag_b == '0) && (count != '0)) last = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            result_q <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg   <= a_neg ^ b_neg;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (last) begin
                        result_q <= neg ? -acc : acc;
                    end else begin
                        acc   <= acc + pp_shifted;
                        mag_b <= mag_b >> BITS_PER_CYCLE;
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
